// File: rtl/hd6309_trace_fifo.sv
// Bus-trace capture FIFO for the HD6309 debugger: 32-bit words, registered pop, sticky overflow.
// Define HD6309_TRACE_TRIGGER_EN to build the address trigger / post-trigger stop logic.
module hd6309_trace_fifo #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  input  logic [31:0]           st_data,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  trig_arm,
  input  logic [15:0]           trig_addr,
  input  logic [DEPTH_LOG2-1:0] trig_post,
  output logic                  triggered,
  output logic                  stopped
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam ptr_t PtrOne    = ptr_t'(1);
  localparam cnt_t CountOne  = cnt_t'(1);
  localparam cnt_t FullCount = cnt_t'(Depth);

  logic [31:0] mem [Depth];

  ptr_t        wr_ptr_q, rd_ptr_q;
  cnt_t        count_q, count_d;
  logic        empty_q, full_q, overflow_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic        stopped_int;

  logic        req, pop, accept, drop;

  always_comb begin
    req    = st_valid & enable & ~stopped_int;
    pop    = rd_en & ~empty_q;
    // At full a same-cycle pop frees the slot the write lands in.
    accept = req & (~full_q | pop);
    drop   = req & full_q & ~pop;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && !clear && !rst) begin
      mem[wr_ptr_q] <= st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrOne;
        rd_data_q <= mem[rd_ptr_q];
      end
      rd_valid_q <= pop;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == FullCount);
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

`ifdef HD6309_TRACE_TRIGGER_EN

  typedef enum logic [1:0] {StIdle, StArmed, StPost, StStopped} trig_state_e;

  trig_state_e state_q;
  ptr_t        post_cnt_q;
  logic        triggered_q, stopped_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= StIdle;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      stopped_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig_arm) begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          // Only stored words can fire the trigger; the trigger word counts as stored.
          if (accept && (st_data[31:16] == trig_addr)) begin
            triggered_q <= 1'b1;
            post_cnt_q  <= trig_post;
            if (trig_post == '0) begin
              state_q   <= StStopped;
              stopped_q <= 1'b1;
            end else begin
              state_q <= StPost;
            end
          end
        end
        StPost: begin
          if (accept) begin
            post_cnt_q <= post_cnt_q - PtrOne;
            if (post_cnt_q == PtrOne) begin
              state_q   <= StStopped;
              stopped_q <= 1'b1;
            end
          end
        end
        StStopped: begin
          stopped_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stopped_int = stopped_q;
  assign triggered   = triggered_q;
  assign stopped     = stopped_q;

`else

  logic unused_trig;
  assign unused_trig = ^{trig_arm, trig_addr, trig_post};

  assign stopped_int = 1'b0;
  assign triggered   = 1'b0;
  assign stopped     = 1'b0;

`endif

endmodule

// File: tb/tb_hd6309_trace_fifo.sv
// Self-checking bench for hd6309_trace_fifo (DEPTH_LOG2=2): vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_hd6309_trace_fifo;

  localparam int DL    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, st_valid, enable, clear, rd_en, trig_arm;
  logic [31:0]   st_data;
  logic [15:0]   trig_addr;
  logic [DL-1:0] trig_post;
  logic [31:0]   rd_data;
  logic          rd_valid, empty, full, overflow, triggered, stopped;
  logic [DL:0]   count;

  hd6309_trace_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_data   (st_data),
    .enable    (enable),
    .clear     (clear),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .trig_arm  (trig_arm),
    .trig_addr (trig_addr),
    .trig_post (trig_post),
    .triggered (triggered),
    .stopped   (stopped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored words as a queue plus a few flags.
  logic [31:0] q[$];
  bit          m_ovf, m_rv;
  logic [31:0] m_rd;
  bit          m_armed, m_seen, m_stop;
  int          m_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_tick();
    bit pop, req, acc, was_idle;
    if (rst || clear) begin
      q.delete();
      m_ovf   = 0;
      m_rv    = 0;
      m_armed = 0;
      m_seen  = 0;
      m_stop  = 0;
      m_left  = 0;
      if (rst) m_rd = '0;
    end else begin
      was_idle = !m_armed && !m_seen;
      pop = rd_en && (q.size() > 0);
      req = st_valid && enable && !m_stop;
      acc = req && ((q.size() < DEPTH) || pop);
      m_rv = pop;
      if (pop) m_rd = q.pop_front();
      if (acc) q.push_back(st_data);
      if (req && !acc) m_ovf = 1;
`ifdef HD6309_TRACE_TRIGGER_EN
      if (acc) begin
        if (m_armed && st_data[31:16] == trig_addr) begin
          m_armed = 0;
          m_seen  = 1;
          m_left  = int'(trig_post);
          if (m_left == 0) m_stop = 1;
        end else if (m_seen && !m_stop) begin
          m_left--;
          if (m_left == 0) m_stop = 1;
        end
      end
      if (was_idle && trig_arm) m_armed = 1;
`endif
    end
  endtask

  task automatic compare_model();
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == DEPTH));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_rd_valid", 32'(rd_valid), 32'(m_rv));
    if (m_rv) chk("m_rd_data", rd_data, m_rd);
    chk("m_triggered", 32'(triggered), 32'(m_seen));
    chk("m_stopped", 32'(stopped), 32'(m_stop));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_tick();
    compare_model();
  endtask

  task automatic idle_inputs();
    rst       = 0;
    st_valid  = 0;
    st_data   = '0;
    enable    = 1;
    clear     = 0;
    rd_en     = 0;
    trig_arm  = 0;
    trig_addr = '0;
    trig_post = '0;
  endtask

  task automatic put(input logic [15:0] addr);
    st_valid = 1;
    st_data  = {addr, 16'h5a40};
    step();
    st_valid = 0;
  endtask

  typedef struct {
    bit          sv;
    logic [31:0] d;
    bit          re;
    bit          clr;
    int          c;
    bit          ov;
    bit          rv;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[$];

  initial begin
    idle_inputs();
    m_rd = '0;
    rst  = 1;
    step();
    rst = 0;
    chk("reset_count", 32'(count), 0);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_full", 32'(full), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_triggered", 32'(triggered), 0);
    chk("reset_stopped", 32'(stopped), 0);

    //             sv  data          re clr cnt ov rv rd
    vt.push_back('{1, 32'h12345600, 0, 0, 1, 0, 0, 0});
    vt.push_back('{1, 32'h12345601, 0, 0, 2, 0, 0, 0});
    vt.push_back('{1, 32'h12345602, 0, 0, 3, 0, 0, 0});
    vt.push_back('{1, 32'h12345603, 0, 0, 4, 0, 0, 0});
    vt.push_back('{0, 32'h0,        1, 0, 3, 0, 1, 32'h12345600});
    vt.push_back('{0, 32'h0,        1, 0, 2, 0, 1, 32'h12345601});
    vt.push_back('{0, 32'h0,        1, 0, 1, 0, 1, 32'h12345602});
    vt.push_back('{0, 32'h0,        1, 0, 0, 0, 1, 32'h12345603});
    vt.push_back('{0, 32'h0,        1, 0, 0, 0, 0, 0});
    vt.push_back('{1, 32'h12345610, 1, 0, 1, 0, 0, 0});
    vt.push_back('{1, 32'h12345611, 0, 0, 2, 0, 0, 0});
    vt.push_back('{1, 32'h12345612, 0, 0, 3, 0, 0, 0});
    vt.push_back('{1, 32'h12345613, 0, 0, 4, 0, 0, 0});
    vt.push_back('{1, 32'h12345614, 1, 0, 4, 0, 1, 32'h12345610});
    vt.push_back('{0, 32'h0,        1, 0, 3, 0, 1, 32'h12345611});
    vt.push_back('{0, 32'h0,        1, 0, 2, 0, 1, 32'h12345612});
    vt.push_back('{0, 32'h0,        1, 0, 1, 0, 1, 32'h12345613});
    vt.push_back('{0, 32'h0,        1, 0, 0, 0, 1, 32'h12345614});
    vt.push_back('{1, 32'h12345620, 0, 0, 1, 0, 0, 0});
    vt.push_back('{1, 32'h12345621, 0, 0, 2, 0, 0, 0});
    vt.push_back('{1, 32'h12345622, 0, 0, 3, 0, 0, 0});
    vt.push_back('{1, 32'h12345623, 0, 0, 4, 0, 0, 0});
    vt.push_back('{1, 32'h12345624, 0, 0, 4, 1, 0, 0});
    vt.push_back('{1, 32'h12345625, 1, 1, 0, 0, 0, 0});
    vt.push_back('{0, 32'h0,        1, 0, 0, 0, 0, 0});

    foreach (vt[i]) begin
      st_valid = vt[i].sv;
      st_data  = vt[i].d;
      rd_en    = vt[i].re;
      clear    = vt[i].clr;
      step();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].c));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].c == DEPTH));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].c == 0));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].ov));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].rv));
      if (vt[i].rv) chk($sformatf("vec%0d_rd_data", i), rd_data, vt[i].rd);
    end
    idle_inputs();

    // Capture disabled: strobe must be ignored.
    enable = 0;
    put(16'h2222);
    enable = 1;
    chk("disabled_count", 32'(count), 0);

`ifdef HD6309_TRACE_TRIGGER_EN
    // Trigger at 0xFFFE with two post-trigger words, then stop.
    trig_addr = 16'hFFFE;
    trig_post = 2'd2;
    trig_arm  = 1;
    step();
    trig_arm = 0;
    put(16'h1000);
    chk("trig_pre_triggered", 32'(triggered), 0);
    put(16'hFFFE);
    chk("trig_fire_triggered", 32'(triggered), 1);
    put(16'h1001);
    chk("trig_post1_stopped", 32'(stopped), 0);
    put(16'h1002);
    chk("trig_post2_stopped", 32'(stopped), 1);
    put(16'h1003);
    chk("trig_stop_count", 32'(count), 4);
    chk("trig_stop_overflow", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp_a [4] = '{16'h1000, 16'hFFFE, 16'h1001, 16'h1002};
      rd_en = 1;
      step();
      chk("trig_pop_addr", 32'(rd_data[31:16]), 32'(exp_a[i]));
    end
    rd_en = 0;
    chk("trig_drained_stopped", 32'(stopped), 1);
    clear = 1;
    step();
    clear = 0;
    chk("trig_clear_stopped", 32'(stopped), 0);
    chk("trig_clear_triggered", 32'(triggered), 0);
`endif

    // Reset during a pop while the trigger is counting post words.
    trig_addr = 16'hFFFE;
    trig_post = 2'd3;
    trig_arm  = 1;
    step();
    trig_arm = 0;
    put(16'hFFFE);
    put(16'h1001);
    rd_en = 1;
    rst   = 1;
    step();
    rd_en = 0;
    rst   = 0;
    chk("rst_mid_rd_valid", 32'(rd_valid), 0);
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_empty", 32'(empty), 1);
    chk("rst_mid_triggered", 32'(triggered), 0);
    chk("rst_mid_rd_data", rd_data, 0);
    // Back in idle: a matching word without re-arming must not fire.
    put(16'hFFFE);
    step();
    chk("rst_idle_triggered", 32'(triggered), 0);
    chk("rst_idle_count", 32'(count), 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      clear     = ($urandom_range(0, 99) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      st_valid  = ($urandom_range(0, 9) < 6);
      st_data   = {16'h1000 + 16'($urandom_range(0, 3)), 16'($urandom)};
      rd_en     = ($urandom_range(0, 9) < 4);
      trig_arm  = ($urandom_range(0, 9) == 0);
      trig_addr = 16'h1000 + 16'($urandom_range(0, 3));
      trig_post = DL'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hd6309_trace_fifo.md
HD6309_TRACE_FIFO -- requirements
Module: hd6309_trace_fifo

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, default 8, log2 of buffer depth in 32-bit words (DEPTH = 2^DEPTH_LOG2).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: st_valid  input  1  one-cycle strobe; trace word present (from bus debugger).
REQ-005 SHALL have port: st_data  input  32  trace word {addr[15:0], data[7:0], rw, bs, 6'b0}.
REQ-006 SHALL have port: enable  input  1  capture enable; st_valid ignored while low.
REQ-007 SHALL have port: clear  input  1  synchronous flush of buffer, flags and trigger state.
REQ-008 SHALL have port: rd_en  input  1  host pop request.
REQ-009 SHALL have port: rd_data  output  32  popped word, valid while rd_valid high.
REQ-010 SHALL have port: rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-011 SHALL have port: count  output  DEPTH_LOG2+1  number of stored words, 0..DEPTH.
REQ-012 SHALL have ports: empty, full, overflow  output  1 each  count==0, count==DEPTH, sticky drop flag.
REQ-013 SHALL have ports: trig_arm input 1, trig_addr input 16, trig_post input DEPTH_LOG2, triggered output 1, stopped output 1.

Function
REQ-014 Write accept = st_valid & enable & ~stopped & (~full | pop); accepted word written at write pointer, pointer incremented modulo DEPTH.
REQ-015 Pop = rd_en & ~empty; read pointer incremented modulo DEPTH; rd_data registered, rd_valid high exactly 1 cycle after pop (latency 1); rd_en while empty ignored, rd_valid stays 0.
REQ-016 Simultaneous accept and pop: count unchanged; at full, pop frees the slot so the write is accepted without overflow.
REQ-017 Empty with simultaneous write and rd_en: write accepted, read ignored (no bypass).
REQ-018 st_valid & enable & ~stopped & full & ~pop: word dropped, overflow set; overflow cleared only by clear or rst.
REQ-019 count, empty, full SHALL reflect state after the current cycle's accept/pop, updated same edge as pointers.
REQ-020 clear has priority over st_valid, rd_en and trig_arm in the same cycle: pointers, count, overflow, rd_valid zeroed; trigger FSM to IDLE.
REQ-021 Trigger FSM states IDLE, ARMED, POST, STOPPED; IDLE->ARMED on trig_arm; trig_arm ignored in other states.
REQ-022 ARMED->POST when an accepted word has st_data[31:16]==trig_addr; remaining counter loaded with trig_post; trigger word itself stored; triggered=1 from next cycle.
REQ-023 POST: each accepted word decrements counter; entering POST with trig_post==0, or counter reaching 0, -> STOPPED after that word is stored.
REQ-024 STOPPED: stopped=1, all writes blocked (no overflow set), reads continue normally; exit only via clear or rst.
REQ-025 Dropped (non-accepted) words SHALL never match the trigger nor decrement the counter.

Reset
REQ-026 On rst high at a clock edge: pointers 0, count 0, empty 1, full 0, overflow 0, rd_valid 0, rd_data 0, triggered 0, stopped 0, FSM IDLE.
REQ-027 rst mid-pop discards the pending rd_valid; buffer memory contents need not be cleared.

Configuration
REQ-028 Macro HD6309_TRACE_TRIGGER_EN defined: trigger FSM of REQ-021..025 built.
REQ-029 Macro undefined: trigger logic omitted, ports retained, trig_* inputs ignored, triggered and stopped tied 0, capture never stops.

Verification
REQ-030 DEPTH_LOG2=2: 4 strobes 0x12345600..0x12345603 -> count=4, full=1; 4 pops -> rd_data same order, each rd_valid 1 cycle after rd_en, empty=1.
REQ-031 Full, 5th strobe without pop -> word dropped, overflow=1, count=4; clear -> overflow=0, count=0, empty=1.
REQ-032 Full, strobe and rd_en same cycle -> count stays 4, overflow=0, newest word read out last.
REQ-033 Empty, rd_en only -> rd_valid stays 0, count 0; rd_en with strobe -> count=1, rd_valid 0.
REQ-034 Macro on: arm, trig_addr=0xFFFE, trig_post=2; words addr 0x1000, 0xFFFE, 0x1001, 0x1002, 0x1003 -> first 4 stored, stopped=1, 0x1003 dropped, overflow=0.
REQ-035 rst asserted during a pop and with FSM in POST -> next cycle rd_valid=0, count=0, triggered=0, FSM IDLE.
